// File: rtl/im_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package im_loader_pkg;

    localparam int unsigned DepthWords  = 2048;
    localparam int unsigned CntWDefault = 12;
    localparam int unsigned AddrW       = 11;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCntHi = 3'd1,
        StCntLo = 3'd2,
        StData  = 3'd3,
        StWrite = 3'd4,
        StDone  = 3'd5
    } state_e;

endpackage

// File: rtl/im_loader.sv
// Loads a length-prefixed big-endian byte stream into the instruction RAM write port.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DepthWords,
    parameter int unsigned CNT_W       = CntWDefault
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  byte_in_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        we_o,
    output logic [12:2] waddr_o,
    output logic [31:0] wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    state_e             state_q, state_d;
    logic [7:0]         cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [1:0]         idx_q, idx_d;
    logic [23:0]        buf_q, buf_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [AddrW-1:0]   waddr_q, waddr_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [15:0]        n_count;
    logic               xfer;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_hi_q    <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            buf_q       <= '0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Ready depends on state only, so there is no path from byte_valid_i to byte_ready_o.
    always_comb begin
        byte_ready_o = (state_q == StCntHi) || (state_q == StCntLo) || (state_q == StData);
        we_o         = (state_q == StWrite);
        done_o       = (state_q == StDone);
        busy_o       = busy_q;
        err_o        = err_q;
        waddr_o      = waddr_q;
        wdata_o      = wdata_q;
    end

    assign xfer    = byte_valid_i && byte_ready_o;
    assign n_count = {cnt_hi_q, byte_in_i};

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;
        busy_d      = busy_q;
        err_d       = err_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StCntHi;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    waddr_d = '0;
                    idx_d   = '0;
                end
            end
            StCntHi: begin
                if (xfer) begin
                    cnt_hi_d = byte_in_i;
                    state_d  = StCntLo;
                end
            end
            StCntLo: begin
                if (xfer) begin
                    if (n_count == 16'd0) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                    end else if (32'(n_count) > DEPTH_WORDS) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        remaining_d = n_count[CNT_W-1:0];
                        state_d     = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    buf_d = {buf_q[15:0], byte_in_i};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wdata_d = {buf_q, byte_in_i};
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                waddr_d = waddr_q + AddrW'(1);
                idx_d   = '0;
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - CNT_W'(1);
                end
                if (remaining_q <= CNT_W'(1)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                end else begin
                    state_d = StData;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench: driver queues expected RAM writes, a negedge monitor checks them.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready, we, busy, done, err;
    logic [12:2] waddr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    im_loader #(
        .DEPTH_WORDS(2048),
        .CNT_W      (12)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .byte_in_i   (byte_in),
        .byte_valid_i(byte_valid),
        .byte_ready_o(byte_ready),
        .we_o        (we),
        .waddr_o     (waddr),
        .wdata_o     (wdata),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_q[$];
    int          exp_done = 0;
    logic [31:0] words[$];
    int          gap_max  = 0;
    wr_t         mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (we) begin
                check("we_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("waddr", 64'(waddr), 64'(mon_e.addr));
                    check("wdata", 64'(wdata), 64'(mon_e.data));
                end
            end
            if (done) begin
                check("done_busy_low", 64'(busy), 0);
                check("done_expected", 64'(exp_done > 0), 1);
                if (exp_done > 0) exp_done--;
            end
            if (busy) check("ready_low_only_in_write", 64'(byte_ready), 64'(!we));
        end
    end

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Called at a negedge; returns at the negedge after the byte has transferred.
    task automatic send_byte(input logic [7:0] b, input bit pulse_start);
        int g;
        int guard;
        g     = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        guard = 0;
        repeat (g) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_in    = b;
        if (pulse_start) start = 1'b1;
        while (!byte_ready && guard < 200) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
        end
        check("byte_ready_wait", 64'(guard < 200), 1);
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic load(input int n, input int abort_at, input int start_at);
        bit          exp_err;
        logic [15:0] nn;
        logic [31:0] w;
        int          guard;
        exp_err = (n > 2048);
        nn      = 16'(n);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 1);
        check("err_cleared_by_start", 64'(err), 0);
        if (!exp_err) begin
            if (abort_at < 0) exp_done++;
            for (int i = 0; i < n; i++) exp_q.push_back({11'(i), words[i]});
        end
        send_byte(nn[15:8], 1'b0);
        send_byte(nn[7:0], 1'b0);
        if (!exp_err) begin
            for (int i = 0; i < n * 4; i++) begin
                if (i == abort_at) break;
                w = words[i / 4];
                send_byte(w[31 - 8 * (i % 4) -: 8], i == start_at);
            end
        end
        if (abort_at >= 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("rst_byte_ready", 64'(byte_ready), 0);
            check("rst_we", 64'(we), 0);
            check("rst_waddr", 64'(waddr), 0);
            check("rst_wdata", 64'(wdata), 0);
            check("rst_busy", 64'(busy), 0);
            check("rst_done", 64'(done), 0);
            check("rst_err", 64'(err), 0);
            exp_q.delete();
            @(negedge clk);
            return;
        end
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("busy_falls", 64'(busy), 0);
        repeat (2) @(negedge clk);
        check("err_after_load", 64'(err), 64'(exp_err));
        check("all_writes_seen", 64'(exp_q.size()), 0);
        check("done_seen", 64'(exp_done), 0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_byte_ready", 64'(byte_ready), 0);
        check("reset_we", 64'(we), 0);
        check("reset_waddr", 64'(waddr), 0);
        check("reset_wdata", 64'(wdata), 0);
        check("reset_busy", 64'(busy), 0);
        check("reset_done", 64'(done), 0);
        check("reset_err", 64'(err), 0);
        reset = 1'b0;
        @(negedge clk);

        words.delete();
        words.push_back(32'h2408_0005);
        load(1, -1, -1);
        check("waddr_after_single", 64'(waddr), 1);

        fill_random(3);
        gap_max = 3;
        load(3, -1, -1);

        gap_max = 0;
        load(0, -1, -1);
        load(16'h0801, -1, -1);
        check("err_sticky", 64'(err), 1);

        fill_random(2048);
        load(2048, -1, -1);
        check("waddr_wraps", 64'(waddr), 0);

        fill_random(4);
        load(4, 6, -1);
        fill_random(1);
        load(1, -1, -1);

        fill_random(3);
        gap_max = 2;
        load(3, -1, 5);

        repeat (6) begin
            fill_random(8);
            gap_max = $urandom_range(0, 3);
            load($urandom_range(1, 8), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
